spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers (1..128).
REQ-002 SHALL have parameter RO_ADDR, default 7, address whose read returns status_in and whose write is ignored.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ssel  input  1  SPI chip select, active low, already synchronised to clk.
REQ-006 SHALL have port byte_received  input  1  one-clk pulse from SPI slave, byte complete.
REQ-007 SHALL have port byte_data_received  input  8  received byte, valid while byte_received=1.
REQ-008 SHALL have port byte_sent  output  8  next byte for the SPI slave to shift out on MISO.
REQ-009 SHALL have port status_in  input  32  read-only status word, sampled at command decode.
REQ-010 SHALL have port regs_flat  output  32*NUM_REGS  register contents; reg i at bits [32*i+31:32*i].
REQ-011 SHALL have port wr_strobe  output  1  one-clk pulse when a register write commits.
REQ-012 SHALL have port wr_addr  output  7  address of the last committed write.

Function
REQ-013 Frame SHALL be 5 bytes: byte0 = {rw, addr[6:0]} (rw=1 write, 0 read), bytes1..4 = data MSB first.
REQ-014 FSM states SHALL be IDLE, CMD, DATA, DISCARD.
REQ-015 IDLE->CMD SHALL occur on the first clk with ssel=0.
REQ-016 In CMD, byte_received SHALL latch rw/addr, clear the byte counter, and move to DATA.
REQ-017 In DATA, each byte_received SHALL shift into a 32-bit assembly register and increment the counter (0..3).
REQ-018 On the 4th data byte: if write, addr<NUM_REGS and addr!=RO_ADDR, register[addr] SHALL update, with wr_strobe=1 and wr_addr=addr on the next clk; FSM SHALL then go to DISCARD.
REQ-019 Writes to addr>=NUM_REGS or addr=RO_ADDR SHALL be dropped with no wr_strobe.
REQ-020 In DISCARD, further bytes SHALL be ignored and byte_sent SHALL be 8'h00.
REQ-021 ssel=1 in any state SHALL return the FSM to IDLE on the next clk; a partial write SHALL be aborted with no register change.
REQ-022 Read data (reg[addr], status_in if addr=RO_ADDR, 0 if addr>=NUM_REGS) SHALL be loaded into a 32-bit output shifter on the clk after the command byte.
REQ-023 byte_sent SHALL equal SYNC_BYTE (8'h5A) in IDLE and CMD.
REQ-024 byte_sent SHALL update exactly 1 clk after byte_received: read data bits [31:24],[23:16],[15:8],[7:0] for bytes 1..4, then 8'h00.
REQ-025 For write frames, byte_sent SHALL echo the previously received byte (1 clk latency).
REQ-026 byte_received coincident with ssel rising SHALL be ignored.

Reset
REQ-027 On rst=1 (asynchronous): FSM=IDLE, all registers=0, regs_flat=0, byte_sent=8'h5A, wr_strobe=0, wr_addr=0, counter=0, shifters=0.
REQ-028 rst asserted mid-frame SHALL discard the frame; the first frame after rst release SHALL decode normally.

Structure
REQ-029 Package spi_reg_pkg SHALL hold the FSM state enum, SYNC_BYTE, FRAME_BYTES=5 and the rw bit position.
REQ-030 Register storage SHALL be a single sub-module reg_bank (write port, combinational read port, flat output).

Verification
REQ-031 Write 0x81,0x12,0x34,0x56,0x78 -> reg1=0x12345678, wr_strobe one pulse, wr_addr=1, regs_flat[63:32]=0x12345678.
REQ-032 After REQ-031, read 0x01 + 4 dummy bytes -> byte_sent sequence 0x5A,0x12,0x34,0x56,0x78.
REQ-033 Read 0x07 with status_in=0xDEADBEEF -> bytes 0xDE,0xAD,0xBE,0xEF; write 0x87,... -> no wr_strobe, reg7 unchanged.
REQ-034 Write 0x82,0xAA,0xBB then ssel=1 -> reg2 stays 0; next full write 0x82,0x01,0x02,0x03,0x04 -> reg2=0x01020304.
REQ-035 Read 0x20 (>=NUM_REGS) -> bytes 0x00 x4; 7-byte frame -> bytes 6..7 ignored, byte_sent=0x00.
REQ-036 rst pulse during byte 3 of a write -> all regs 0, byte_sent=0x5A, next frame decodes correctly.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge.
// Frame: one command byte {rw, addr[6:0]} followed by four data bytes, MSB first.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DISCARD
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
    } cmd_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h5A;
    localparam int         FRAME_BYTES = 5;
    localparam int         RW_BIT      = 7;

endpackage

// File: rtl/spi_reg_bridge_reg_bank.sv
// Register file: one write port committing on the clk edge with we high, combinational read, flat image.
// Zero-latency read, one-clk write; no backpressure.
module reg_bank #(
    parameter int NUM_REGS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [6:0]              waddr,
    input  logic [31:0]             wdata,
    input  logic [6:0]              raddr,
    output logic [31:0]             rdata,
    output logic [32*NUM_REGS-1:0]  regs_flat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_flat <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == 7'(i)) begin
                    regs_flat[32*i +: 32] <= wdata;
                end
            end
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 7'(i)) begin
                rdata = regs_flat[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI command/data frame decoder driving a small register bank and a read-back shifter.
// byte_sent and wr_strobe respond one clk after byte_received; no backpressure, ssel high aborts a frame.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int RO_ADDR  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ssel,
    input  logic                    byte_received,
    input  logic [7:0]              byte_data_received,
    output logic [7:0]              byte_sent,
    input  logic [31:0]             status_in,
    output logic [32*NUM_REGS-1:0]  regs_flat,
    output logic                    wr_strobe,
    output logic [6:0]              wr_addr
);

    localparam logic [7:0] REG_LIMIT = 8'(NUM_REGS);
    localparam logic [6:0] RO_SEL    = 7'(RO_ADDR);
    localparam logic [1:0] LAST_DATA = 2'(FRAME_BYTES - 2);

    state_t      state;
    state_t      state_nxt;
    cmd_t        cmd;
    cmd_t        cmd_in;
    logic [1:0]  cnt;
    logic [23:0] asm_dat;
    logic [23:0] tx_shift;
    logic [7:0]  tx_byte;
    logic        cmd_take;
    logic        data_take;
    logic        commit;
    logic        wr_ok;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] bank_rdata;

    assign cmd_in  = '{rw: byte_data_received[RW_BIT], addr: byte_data_received[6:0]};
    assign rd_addr = byte_data_received[6:0];
    assign wr_ok   = ({1'b0, cmd.addr} < REG_LIMIT) && (cmd.addr != RO_SEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!ssel) state_nxt = CMD;
            CMD:     if (cmd_take) state_nxt = DATA;
            DATA:    if (data_take && (cnt == LAST_DATA)) state_nxt = DISCARD;
            DISCARD: state_nxt = DISCARD;
            default: state_nxt = IDLE;
        endcase
        // Deselect wins over everything, including a byte landing in the same clk.
        if (ssel) state_nxt = IDLE;
    end

    always_comb begin
        cmd_take  = 1'b0;
        data_take = 1'b0;
        if (!ssel && byte_received) begin
            cmd_take  = (state == CMD);
            data_take = (state == DATA);
        end
        commit = data_take && (cnt == LAST_DATA) && cmd.rw && wr_ok;
        case (state)
            IDLE, CMD: byte_sent = SYNC_BYTE;
            DATA:      byte_sent = tx_byte;
            DISCARD:   byte_sent = 8'h00;
            default:   byte_sent = SYNC_BYTE;
        endcase
    end

    // Read source is chosen from the command byte itself so data is ready one clk later.
    always_comb begin
        if (rd_addr == RO_SEL) begin
            rd_data = status_in;
        end else if ({1'b0, rd_addr} < REG_LIMIT) begin
            rd_data = bank_rdata;
        end else begin
            rd_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd       <= '0;
            cnt       <= '0;
            asm_dat   <= '0;
            tx_shift  <= '0;
            tx_byte   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= cmd.addr;
            end
            if (cmd_take) begin
                cmd      <= cmd_in;
                cnt      <= '0;
                asm_dat  <= '0;
                tx_byte  <= cmd_in.rw ? byte_data_received : rd_data[31:24];
                tx_shift <= rd_data[23:0];
            end else if (data_take) begin
                cnt      <= cnt + 2'd1;
                asm_dat  <= {asm_dat[15:0], byte_data_received};
                tx_byte  <= cmd.rw ? byte_data_received : tx_shift[23:16];
                tx_shift <= {tx_shift[15:0], 8'h00};
            end
        end
    end

    reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (commit),
        .waddr     (cmd.addr),
        .wdata     ({asm_dat, byte_data_received}),
        .raddr     (rd_addr),
        .rdata     (bank_rdata),
        .regs_flat (regs_flat)
    );

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed frame table, hand-built corner sequences, then random frames
// compared against a frame-level model of the register map.
module tb_spi_reg_bridge;

    localparam int NREG = 8;
    localparam int RO   = 7;
    localparam int NVEC = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ssel = 1'b1;
    logic               byte_received = 1'b0;
    logic [7:0]         byte_data_received = 8'h00;
    logic [7:0]         byte_sent;
    logic [31:0]        status_in = 32'h0;
    logic [32*NREG-1:0] regs_flat;
    logic               wr_strobe;
    logic [6:0]         wr_addr;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    logic [7:0]  tx_b   [7];
    logic [7:0]  seen_b [7];
    logic [7:0]  post_b [7];
    logic        stb_b  [7];
    logic [7:0]  exp_b  [7];
    logic [31:0] mreg   [128];
    logic [6:0]  m_wa;

    typedef struct packed {
        int          n;
        logic [55:0] tx;
        logic [31:0] status;
        logic [55:0] rx;
        int          strobes;
        logic [6:0]  ra;
        logic [31:0] rv;
        logic [6:0]  wa;
    } vec_t;

    vec_t vecs [NVEC];

    spi_reg_bridge #(
        .NUM_REGS (NREG),
        .RO_ADDR  (RO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ssel               (ssel),
        .byte_received      (byte_received),
        .byte_data_received (byte_data_received),
        .byte_sent          (byte_sent),
        .status_in          (status_in),
        .regs_flat          (regs_flat),
        .wr_strobe          (wr_strobe),
        .wr_addr            (wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] seen,
                             output logic [7:0] post, output logic stb);
        @(negedge clk);
        seen = byte_sent;
        byte_received = 1'b1;
        byte_data_received = b;
        @(negedge clk);
        byte_received = 1'b0;
        post = byte_sent;
        stb = wr_strobe;
        byte_data_received = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic run_frame(input int n, output int strobes);
        int s0;
        s0 = strobe_cnt;
        @(negedge clk);
        ssel = 1'b0;
        for (int k = 0; k < n; k++) send_byte(tx_b[k], seen_b[k], post_b[k], stb_b[k]);
        @(negedge clk);
        ssel = 1'b1;
        repeat (2) @(negedge clk);
        strobes = strobe_cnt - s0;
    endtask

    // Frame-level model: what each shifted-out byte should be and what the register map becomes.
    task automatic model_frame(input int n, output int exp_strobes);
        logic        rw;
        logic [6:0]  a;
        logic [31:0] word;
        rw = tx_b[0][7];
        a  = tx_b[0][6:0];
        if (int'(a) == RO) word = status_in;
        else if (int'(a) < NREG) word = mreg[a];
        else word = 32'h0;
        exp_b[0] = 8'h5A;
        for (int k = 1; k < 7; k++) begin
            if (k > 4) exp_b[k] = 8'h00;
            else if (rw) exp_b[k] = tx_b[k-1];
            else exp_b[k] = word[8*(4-k) +: 8];
        end
        exp_strobes = 0;
        if (rw && n >= 5 && int'(a) < NREG && int'(a) != RO) begin
            mreg[a] = {tx_b[1], tx_b[2], tx_b[3], tx_b[4]};
            m_wa = a;
            exp_strobes = 1;
        end
    endtask

    task automatic model_run(input string tag, input int n);
        int es;
        int st;
        model_frame(n, es);
        run_frame(n, st);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_byte%0d", tag, k), 32'(seen_b[k]), 32'(exp_b[k]));
        chk($sformatf("%s_strobes", tag), 32'(st), 32'(es));
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s_reg%0d", tag, i), regs_flat[32*i +: 32], mreg[7'(i)]);
        chk($sformatf("%s_wr_addr", tag), 32'(wr_addr), 32'(m_wa));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        int st;
        int s0;
        vecs[0] = '{n: 5, tx: 56'h81_12_34_56_78_00_00, status: 32'h0,
                    rx: 56'h5A_81_12_34_56_00_00, strobes: 1, ra: 7'd1, rv: 32'h12345678, wa: 7'd1};
        vecs[1] = '{n: 5, tx: 56'h01_00_00_00_00_00_00, status: 32'h0,
                    rx: 56'h5A_12_34_56_78_00_00, strobes: 0, ra: 7'd1, rv: 32'h12345678, wa: 7'd1};
        vecs[2] = '{n: 5, tx: 56'h07_FF_FF_FF_FF_00_00, status: 32'hDEADBEEF,
                    rx: 56'h5A_DE_AD_BE_EF_00_00, strobes: 0, ra: 7'd7, rv: 32'h0, wa: 7'd1};
        vecs[3] = '{n: 5, tx: 56'h87_11_22_33_44_00_00, status: 32'hDEADBEEF,
                    rx: 56'h5A_87_11_22_33_00_00, strobes: 0, ra: 7'd7, rv: 32'h0, wa: 7'd1};
        vecs[4] = '{n: 5, tx: 56'h20_00_00_00_00_00_00, status: 32'h0,
                    rx: 56'h5A_00_00_00_00_00_00, strobes: 0, ra: 7'd1, rv: 32'h12345678, wa: 7'd1};
        vecs[5] = '{n: 7, tx: 56'h01_00_00_00_00_00_00, status: 32'h0,
                    rx: 56'h5A_12_34_56_78_00_00, strobes: 0, ra: 7'd1, rv: 32'h12345678, wa: 7'd1};
        vecs[6] = '{n: 3, tx: 56'h82_AA_BB_00_00_00_00, status: 32'h0,
                    rx: 56'h5A_82_AA_00_00_00_00, strobes: 0, ra: 7'd2, rv: 32'h0, wa: 7'd1};
        vecs[7] = '{n: 5, tx: 56'h82_01_02_03_04_00_00, status: 32'h0,
                    rx: 56'h5A_82_01_02_03_00_00, strobes: 1, ra: 7'd2, rv: 32'h01020304, wa: 7'd2};
        vecs[8] = '{n: 7, tx: 56'h85_CA_FE_BA_BE_99_88, status: 32'h0,
                    rx: 56'h5A_85_CA_FE_BA_00_00, strobes: 1, ra: 7'd5, rv: 32'hCAFEBABE, wa: 7'd5};

        // Reset state
        #12;
        chk("rst_byte_sent", 32'(byte_sent), 32'h5A);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_regs_flat_any", 32'(|regs_flat), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame table
        for (int v = 0; v < NVEC; v++) begin
            status_in = vecs[v].status;
            for (int k = 0; k < 7; k++) tx_b[k] = vecs[v].tx[55-8*k -: 8];
            run_frame(vecs[v].n, st);
            for (int k = 0; k < vecs[v].n; k++)
                chk($sformatf("vec%0d_byte%0d", v, k), 32'(seen_b[k]), 32'(vecs[v].rx[55-8*k -: 8]));
            chk($sformatf("vec%0d_strobes", v), 32'(st), 32'(vecs[v].strobes));
            chk($sformatf("vec%0d_reg%0d", v, vecs[v].ra),
                regs_flat[32*int'(vecs[v].ra) +: 32], vecs[v].rv);
            chk($sformatf("vec%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].wa));
        end

        // One-clk response timing on write commit and read load
        @(negedge clk);
        ssel = 1'b0;
        send_byte(8'h84, seen_b[0], post_b[0], stb_b[0]);
        chk("lat_echo_cmd", 32'(post_b[0]), 32'h84);
        send_byte(8'h11, seen_b[1], post_b[1], stb_b[1]);
        send_byte(8'h22, seen_b[2], post_b[2], stb_b[2]);
        send_byte(8'h33, seen_b[3], post_b[3], stb_b[3]);
        chk("lat_no_early_strobe", 32'(stb_b[3]), 32'h0);
        @(negedge clk);
        byte_received = 1'b1;
        byte_data_received = 8'h44;
        @(negedge clk);
        byte_received = 1'b0;
        chk("lat_strobe_next_clk", 32'(wr_strobe), 32'h1);
        chk("lat_wr_addr", 32'(wr_addr), 32'h4);
        chk("lat_reg4", regs_flat[32*4 +: 32], 32'h11223344);
        chk("lat_discard_byte", 32'(byte_sent), 32'h00);
        @(negedge clk);
        chk("lat_strobe_one_pulse", 32'(wr_strobe), 32'h0);
        ssel = 1'b1;
        repeat (2) @(negedge clk);
        ssel = 1'b0;
        send_byte(8'h04, seen_b[0], post_b[0], stb_b[0]);
        chk("lat_read_first", 32'(post_b[0]), 32'h11);
        ssel = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a write frame
        ssel = 1'b0;
        send_byte(8'h85, seen_b[0], post_b[0], stb_b[0]);
        send_byte(8'h11, seen_b[1], post_b[1], stb_b[1]);
        @(negedge clk);
        byte_received = 1'b1;
        byte_data_received = 8'h22;
        #2 rst = 1'b1;
        #1;
        chk("midrst_byte_sent", 32'(byte_sent), 32'h5A);
        chk("midrst_regs_flat_any", 32'(|regs_flat), 32'h0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
        @(negedge clk);
        byte_received = 1'b0;
        ssel = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 128; i++) mreg[7'(i)] = 32'h0;
        m_wa = 7'd0;
        tx_b[0] = 8'h83; tx_b[1] = 8'hCA; tx_b[2] = 8'hFE; tx_b[3] = 8'hF0; tx_b[4] = 8'h0D;
        model_run("postrst", 5);

        // Byte landing in the same clk as deselect must be dropped
        s0 = strobe_cnt;
        @(negedge clk);
        ssel = 1'b0;
        send_byte(8'h86, seen_b[0], post_b[0], stb_b[0]);
        send_byte(8'h01, seen_b[1], post_b[1], stb_b[1]);
        send_byte(8'h02, seen_b[2], post_b[2], stb_b[2]);
        send_byte(8'h03, seen_b[3], post_b[3], stb_b[3]);
        @(negedge clk);
        byte_received = 1'b1;
        byte_data_received = 8'h04;
        ssel = 1'b1;
        @(negedge clk);
        byte_received = 1'b0;
        chk("coinc_no_strobe", 32'(wr_strobe), 32'h0);
        chk("coinc_idle_sync", 32'(byte_sent), 32'h5A);
        repeat (2) @(negedge clk);
        chk("coinc_strobe_count", 32'(strobe_cnt - s0), 32'h0);
        chk("coinc_reg6", regs_flat[32*6 +: 32], mreg[7'd6]);

        // Random frames against the model
        for (int it = 0; it < 60; it++) begin
            int n;
            logic [6:0] a;
            n = ($urandom_range(1, 0) == 1) ? 5 : int'($urandom_range(7, 1));
            a = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'($urandom_range(9, 0));
            tx_b[0] = {1'($urandom), a};
            for (int k = 1; k < 7; k++) tx_b[k] = 8'($urandom);
            status_in = $urandom;
            model_run($sformatf("rnd%0d", it), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
